// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: Gray-code position sweep sequencer with start/done handshake
module gray_sweep_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] cfg_start,
    input  logic [N-1:0] cfg_steps,
    input  logic         cfg_dir,
    input  logic         cfg_wrap_en,
    input  logic         pause,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         step_valid,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] bin_q, bin_d, rem_q, rem_d;
    logic         dir_q, dir_d, err_q, err_d, sv_q, sv_d;
    logic [N:0]   sum;
    logic         reject;

    assign sum    = {1'b0, cfg_start} + {1'b0, cfg_steps};
    assign reject = !cfg_wrap_en && (cfg_dir ? sum[N] : (cfg_steps > cfg_start));

    // Next-state: command acceptance in IDLE, stepping/abort/pause in RUN
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        sv_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (reject) err_d = 1'b1;
                else begin
                    bin_d   = cfg_start;
                    rem_d   = cfg_steps;
                    dir_d   = cfg_dir;
                    state_d = (cfg_steps == '0) ? FIN : RUN;
                end
            end
            RUN: if (abort) state_d = IDLE;
            else if (!pause) begin
                bin_d   = dir_q ? bin_q + ONE : bin_q - ONE;
                rem_d   = rem_q - ONE;
                sv_d    = 1'b1;
                state_d = (rem_q == ONE) ? FIN : RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, cleared asynchronously so a mid-sweep reset lands in IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            sv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            sv_q    <= sv_d;
        end
    end

    assign busy       = (state_q == RUN);
    assign done       = (state_q == FIN);
    assign err        = err_q;
    assign step_valid = sv_q;
    assign bin_out    = bin_q;
    assign gray_out   = bin_q ^ (bin_q >> 1);
endmodule
